// File: rtl/signed_divider_nr.sv
// signed_divider_nr: sequential signed 8-bit divider, non-restoring,
// one quotient bit per clock, truncating quotient, remainder follows dividend.
module signed_divider_nr (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic       overflow
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [8:0]  r_rem;     // signed partial remainder
    logic [8:0]  r_dvs;     // divisor magnitude (128 fits because bit 8 is zero)
    logic [7:0]  r_dvd;     // raw dividend, needed for the divide-by-zero remainder
    logic [2:0]  r_cnt;
    logic        r_sign_q, r_sign_r, r_dz, r_ov;
    logic [7:0]  r_qres, r_rres;

    logic [7:0]  w_dvd_mag, w_dvs_mag, w_rfix;
    logic [8:0]  w_shr, w_iter;

    // Operand magnitudes; -128 maps to 8'h80 which reads as 128 unsigned.
    assign w_dvd_mag = dividend[7] ? (~dividend + 8'd1) : dividend;
    assign w_dvs_mag = divisor[7]  ? (~divisor  + 8'd1) : divisor;

    // One non-restoring step: shift {R,Q} left, then add or subtract by sign of R.
    assign w_shr  = {r_rem[7:0], r_q[7]};
    assign w_iter = r_rem[8] ? (w_shr + r_dvs) : (w_shr - r_dvs);

    // Final restore of a negative remainder; result is in [0,|divisor|) so 8 bits suffice.
    assign w_rfix = r_rem[8] ? 8'(r_rem + r_dvs) : r_rem[7:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == 3'd0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; results publish only when DONE is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0; r_rem <= '0; r_dvs <= '0; r_dvd <= '0; r_cnt <= '0;
            r_sign_q <= 1'b0; r_sign_r <= 1'b0; r_dz <= 1'b0; r_ov <= 1'b0;
            r_qres <= '0; r_rres <= '0;
            quotient <= '0; remainder <= '0; busy <= 1'b0; done <= 1'b0;
            div_by_zero <= 1'b0; overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_q      <= w_dvd_mag;
                    r_dvs    <= {1'b0, w_dvs_mag};
                    r_dvd    <= dividend;
                    r_rem    <= '0;
                    r_cnt    <= 3'd7;
                    r_sign_q <= dividend[7] ^ divisor[7];
                    r_sign_r <= dividend[7];
                    r_dz     <= (divisor == 8'h00);
                    r_ov     <= (dividend == 8'h80) && (divisor == 8'hFF);
                    busy     <= 1'b1;
                end
                S_CALC: begin
                    r_rem <= w_iter;
                    r_q   <= {r_q[6:0], ~w_iter[8]};
                    r_cnt <= r_cnt - 3'd1;
                end
                S_FIX: begin
                    // Special cases override the datapath so latency stays uniform.
                    if (r_dz) begin
                        r_qres <= 8'hFF;
                        r_rres <= r_dvd;
                    end else if (r_ov) begin
                        r_qres <= 8'h80;
                        r_rres <= 8'h00;
                    end else begin
                        r_qres <= r_sign_q ? (~r_q + 8'd1) : r_q;
                        r_rres <= r_sign_r ? (~w_rfix + 8'd1) : w_rfix;
                    end
                end
                S_DONE: begin
                    quotient    <= r_qres;
                    remainder   <= r_rres;
                    div_by_zero <= r_dz;
                    overflow    <= r_ov;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_nr.sv
// Testbench for signed_divider_nr: directed cases plus randomized back-to-back
// operations checked against an integer-arithmetic reference model.
module tb_signed_divider_nr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero, overflow;

    int n_pass = 0;
    int n_total = 0;

    signed_divider_nr dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: C-style truncating division with the two special-case rules.
    // Packed as {quotient, remainder, div_by_zero, overflow}.
    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
        int ia, ib, q, r;
        logic [7:0] q8, r8;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0)                     return {8'hFF, a, 1'b1, 1'b0};
        if (ia == -128 && ib == -1)      return {8'h80, 8'h00, 1'b0, 1'b1};
        q = ia / ib;
        r = ia % ib;
        q8 = q[7:0];
        r8 = r[7:0];
        return {q8, r8, 1'b0, 1'b0};
    endfunction

    function automatic logic [17:0] outs();
        return {quotient, remainder, div_by_zero, overflow};
    endfunction

    // Issue one operation and wait (bounded) for done; lat = clocks from accept edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [17:0] res, output int lat);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        res = outs();
        if (!done) begin
            n_total++;
            $display("FAIL op_timeout: no done for %0d/%0d within 30 clocks",
                     $signed(a), $signed(b));
        end
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({outs(), busy, done} !== 20'h0)
            $display("FAIL reset_async: got %h want 00000", {outs(), busy, done});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({outs(), busy, done} !== 20'h0)
            $display("FAIL reset_clocked: got %h want 00000", {outs(), busy, done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 100/7 with cycle-accurate busy/done checks; first start after reset release.
    task automatic test_basic();
        dividend = 8'h64; divisor = 8'h07; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL basic_busy cyc%0d: busy=%b done=%b want busy=1 done=0", i, busy, done);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (done !== 1'b0) $display("FAIL basic_early_done: done=%b want 0", done);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b1 || outs() !== {8'h0E, 8'h02, 2'b00})
            $display("FAIL basic_result: done=%b got %h want %h", done, outs(), {8'h0E, 8'h02, 2'b00});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b0 || outs() !== {8'h0E, 8'h02, 2'b00})
            $display("FAIL basic_pulse_hold: done=%b got %h", done, outs());
        else n_pass++;
    endtask

    // Directed signs and special cases; 5/0 then 9/3 shows the flag clearing.
    task automatic test_signs_special();
        logic [7:0]  ta[7] = '{8'h9C, 8'h64, 8'h80, 8'h80, 8'h05, 8'h09, 8'h7F};
        logic [7:0]  tb[7] = '{8'h07, 8'hF9, 8'hFF, 8'h01, 8'h00, 8'h03, 8'h80};
        logic [17:0] te[7] = '{{8'hF2, 8'hFE, 2'b00}, {8'hF2, 8'h02, 2'b00},
                               {8'h80, 8'h00, 2'b01}, {8'h80, 8'h00, 2'b00},
                               {8'hFF, 8'h05, 2'b10}, {8'h03, 8'h00, 2'b00},
                               {8'h00, 8'h7F, 2'b00}};
        logic [17:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], res, lat);
            n_total++;
            if (res !== te[i] || lat != 10)
                $display("FAIL signs_special %h/%h: got %h lat %0d want %h lat 10",
                         ta[i], tb[i], res, lat, te[i]);
            else n_pass++;
        end
    endtask

    // A start pulse during CALC must not disturb the running operation.
    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = 8'd77; divisor = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (done !== 1'b1 || outs() !== {8'h0A, 8'h00, 2'b00})
            $display("FAIL ignore_start: done=%b got %h want %h", done, outs(), {8'h0A, 8'h00, 2'b00});
        else n_pass++;
        repeat (30) begin
            @(posedge clk); #1;
            n_total++;
            if (done !== 1'b0) $display("FAIL ignore_start_extra_done: done=%b want 0", done);
            else n_pass++;
        end
    endtask

    // Reset mid-CALC clears outputs without a clock edge and kills the operation.
    task automatic test_reset_mid();
        logic [17:0] res;
        int lat;
        @(negedge clk);
        dividend = 8'h21; divisor = 8'h04; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({outs(), busy, done} !== 20'h0)
            $display("FAIL reset_mid_async: got %h want 00000", {outs(), busy, done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_mid_discard: done=%b busy=%b want 0 0", done, busy);
            else n_pass++;
        end
        run_op(8'hF3, 8'h04, res, lat);
        n_total++;
        if (res !== model(8'hF3, 8'h04) || lat != 10)
            $display("FAIL reset_mid_recover: got %h lat %0d want %h", res, lat, model(8'hF3, 8'h04));
        else n_pass++;
    endtask

    // start held high: one accept every 11 clocks, one done per accept.
    task automatic test_back_to_back();
        localparam int N = 600;
        logic [7:0] corner[6] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h81};
        logic [7:0] opa[N], opb[N];
        int lat;
        for (int k = 0; k < N; k++) begin
            if (k < 36) begin
                opa[k] = corner[k / 6];
                opb[k] = corner[k % 6];
            end else begin
                opa[k] = 8'($urandom);
                opb[k] = 8'($urandom);
            end
        end
        @(negedge clk);
        dividend = opa[0]; divisor = opb[0]; start = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            if (k + 1 < N) begin
                dividend = opa[k+1]; divisor = opb[k+1];
            end else start = 1'b0;
            lat = 0;
            while (!done && lat < 30) begin
                @(posedge clk); #1;
                lat++;
            end
            n_total++;
            if (outs() !== model(opa[k], opb[k]) || lat != 10 || done !== 1'b1)
                $display("FAIL back_to_back #%0d %h/%h: got %h lat %0d want %h lat 10",
                         k, opa[k], opb[k], outs(), lat, model(opa[k], opb[k]));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs_special();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
